dat_sc_extract: RTL

//  Downstream of Ch_EstEqu in the 802.16 OFDM RX chain. Takes equalized 256-bin symbols in natural FFT

---
 rtl/dat_sc_extract_pkg.sv | 19 +
 rtl/dat_sc_extract_bin_seq.sv | 37 +++
 rtl/dat_sc_extract.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dat_sc_extract_pkg.sv
// Shared constants for the 802.16 data-subcarrier extractor: FFT size, data count,
// sample width and the fixed pilot-bin map.
package dat_sc_extract_pkg;
    localparam int SC_DW = 16;
    localparam int NFFT  = 256;
    localparam int NDATA = 192;

    // Read sweep starts at the most negative data bin and ends at the most positive one
    localparam logic [7:0] FIRST_BIN = 8'd156;
    localparam logic [7:0] LAST_BIN  = 8'd100;

    function automatic logic is_pilot(input logic [7:0] bin);
        case (bin)
            8'd168, 8'd193, 8'd218, 8'd243,
            8'd13,  8'd38,  8'd63,  8'd88: is_pilot = 1'b1;
            default:                       is_pilot = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/dat_sc_extract_bin_seq.sv
// Read-side bin sequencer: walks 156..255 then 1..100, skipping pilot bins,
// so exactly 192 bins are visited per symbol.
module dat_sc_extract_bin_seq
    import dat_sc_extract_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [7:0] rd_bin,
    output logic       rd_last
);

    logic [7:0] inc_bin;
    logic [7:0] nxt_bin;

    assign inc_bin = rd_bin + 8'd1;
    assign rd_last = (rd_bin == LAST_BIN);

    // Pilots are never adjacent, so a single extra step clears any pilot
    always_comb begin
        nxt_bin = inc_bin;
        if (rd_bin == LAST_BIN)
            nxt_bin = FIRST_BIN;
        else if (inc_bin == 8'd0)
            nxt_bin = 8'd1;
        else if (is_pilot(inc_bin))
            nxt_bin = inc_bin + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_bin <= FIRST_BIN;
        else if (adv)
            rd_bin <= nxt_bin;
    end

endmodule

// File: rtl/dat_sc_extract.sv
// Data-subcarrier extractor: buffers 256-bin symbols in a 2-bank ping-pong RAM and
// emits the 192 data bins in ascending logical frequency.
module dat_sc_extract
    import dat_sc_extract_pkg::*;
#(
    parameter int DW = SC_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] dat_i,
    input  logic            cyc_i,
    input  logic            we_i,
    input  logic            stb_i,
    output logic            ack_o,
    output logic [2*DW-1:0] dat_o,
    output logic            we_o,
    output logic            stb_o,
    output logic            cyc_o,
    input  logic            ack_i
);

    // state   | meaning
    // RD_IDLE | waiting for the bank at rd_bank to become full
    // RD_RUN  | issuing RAM reads for the data bins of rd_bank
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RUN  = 1'b1;

    logic [2*DW-1:0] mem [0:2*NFFT-1];
    logic [2*DW-1:0] ram_q;
    logic [7:0]      wc;
    logic            wr_bank, rd_bank, fr_bank;
    logic [1:0]      full, set_full, clr_full;
    logic [0:0]      rd_state;
    logic [7:0]      rd_bin;
    logic            rd_last, rd_en;
    logic            q_vld, q_last, out_last;
    logic            out_hs, out_ready, s1_ready;

    assign ack_o     = rst_n & cyc_i & stb_i & we_i & ~full[wr_bank];
    assign out_hs    = stb_o & ack_i;
    assign out_ready = ~stb_o | ack_i;
    assign s1_ready  = ~q_vld | out_ready;
    assign rd_en     = (rd_state == RD_RUN) & s1_ready;
    assign we_o      = stb_o;

    assign set_full = (ack_o && wc == 8'hFF) ? {wr_bank, ~wr_bank} : 2'b00;
    assign clr_full = (out_hs && out_last)   ? {fr_bank, ~fr_bank} : 2'b00;

    dat_sc_extract_bin_seq u_bin_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (rd_en),
        .rd_bin  (rd_bin),
        .rd_last (rd_last)
    );

    always_ff @(posedge clk) begin
        if (ack_o)
            mem[{wr_bank, wc}] <= dat_i;
        if (rd_en)
            ram_q <= mem[{rd_bank, rd_bin}];
    end

    // An aborted frame leaves its bank free; only a completed bin 255 marks it full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc      <= 8'd0;
            wr_bank <= 1'b0;
            fr_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            full <= (full & ~clr_full) | set_full;
            if (clr_full != 2'b00)
                fr_bank <= ~fr_bank;
            if (ack_o) begin
                wc <= wc + 8'd1;
                if (wc == 8'hFF)
                    wr_bank <= ~wr_bank;
            end else if (!cyc_i && wc != 8'd0) begin
                wc <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_bank  <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: if (full[rd_bank]) rd_state <= RD_RUN;
                RD_RUN: begin
                    if (rd_en && rd_last) begin
                        rd_state <= RD_IDLE;
                        rd_bank  <= ~rd_bank;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // ram_q is only re-read when the stage behind it can take its value, so it doubles as the skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld    <= 1'b0;
            q_last   <= 1'b0;
            stb_o    <= 1'b0;
            out_last <= 1'b0;
            dat_o    <= '0;
            cyc_o    <= 1'b0;
        end else begin
            if (s1_ready) begin
                q_vld  <= rd_en;
                q_last <= rd_last;
            end
            if (out_ready) begin
                stb_o    <= q_vld;
                out_last <= q_vld & q_last;
                if (q_vld)
                    dat_o <= ram_q;
            end
            if (out_ready && q_vld)
                cyc_o <= 1'b1;
            else if (!stb_o && !q_vld && full == 2'b00 && !cyc_i && wc == 8'd0)
                cyc_o <= 1'b0;
        end
    end

endmodule
